// File: rtl/vga_pkg.sv
// Shared constants for the 800x600 @ 60 Hz raster: porch/sync sizes,
// derived totals and sync windows, and the common counter width.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam logic SYNC_POL = 1'b1;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int CNT_W = 11;

  // Half-open window test [lo, hi) used for the sync pulses.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Raster position bundle: the timing generator drives it through `out`,
// draw stages consume it through `in`.
interface vga_if;

  logic [vga_pkg::CNT_W-1:0] hcount;
  logic [vga_pkg::CNT_W-1:0] vcount;
  logic                      hsync;
  logic                      vsync;
  logic                      hblnk;
  logic                      vblnk;

  modport out (output hcount, output vcount, output hsync, output vsync,
               output hblnk, output vblnk);
  modport in  (input hcount, input vcount, input hsync, input vsync,
               input hblnk, input vblnk);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with blank and sync flags
// registered in the same stage as the count they describe.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   TOTAL  = H_TOTAL,
  parameter int   ACTIVE = H_ACTIVE,
  parameter int   FP     = H_FP,
  parameter int   SYNC   = H_SYNC,
  parameter logic POL    = SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT     = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] S_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_END   = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count_d, count_q;
  logic             blnk_d, blnk_q;
  logic             sync_d, sync_q;

  // Flags are derived from the next count so they land alongside it.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      count_d = count_q;
    end
    blnk_d = (count_d >= ACT);
    if (in_window(count_d, S_START, S_END)) begin
      sync_d = POL;
    end else begin
      sync_d = ~POL;
    end
  end

  // Axis state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;
  assign wrap  = inc && (count_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: chains horizontal and vertical axis counters
// and produces the per-line and per-frame ticks.
module vga_timing #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic     clk,
  input  logic     rst,
  vga_if.out       vout,
  output logic     frame_tick,
  output logic     line_tick
);

  localparam int W  = vga_pkg::CNT_W;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [W-1:0] LINE_PRE  = W'(H_ACTIVE - 1);
  localparam logic [W-1:0] FRAME_PRE = W'(V_ACTIVE - 1);

  logic [W-1:0] h_count, v_count;
  logic         h_blnk, v_blnk, h_sync, v_sync, h_wrap, v_wrap;
  logic         frame_tick_d, frame_tick_q;
  logic         line_tick_d, line_tick_q;

  vga_axis_counter #(
    .TOTAL (HT), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .inc(1'b1),
    .count(h_count), .blnk(h_blnk), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .TOTAL (VT), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .inc(h_wrap),
    .count(v_count), .blnk(v_blnk), .sync(v_sync), .wrap(v_wrap)
  );

  // Ticks are decoded one position early so they register alongside
  // the counters: (0, V_ACTIVE) follows a wrap out of line V_ACTIVE-1.
  always_comb begin
    line_tick_d  = (h_count == LINE_PRE);
    frame_tick_d = h_wrap && (v_count == FRAME_PRE);
  end

  // Tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vout.hcount = h_count;
  assign vout.vcount = v_count;
  assign vout.hsync  = h_sync;
  assign vout.vsync  = v_sync;
  assign vout.hblnk  = h_blnk;
  assign vout.vblnk  = v_blnk;
  assign frame_tick  = frame_tick_q;
  assign line_tick   = line_tick_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a scaled-down raster (positive sync) and the full
// 800x600 raster with negative sync, both against a position-from-cycle model.
module tb_vga_timing;

  // Small raster: 28 x 16, frame = 448 clocks.
  localparam int S_HA = 16, S_HFP = 3, S_HS = 5, S_HBP = 4;
  localparam int S_VA = 10, S_VFP = 1, S_VS = 2, S_VBP = 3;
  // Full raster with negative sync.
  localparam int D_HA = 800, D_HFP = 40, D_HS = 128, D_HBP = 88;
  localparam int D_VA = 600, D_VFP = 1, D_VS = 4, D_VBP = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ft_s, lt_s, ft_d, lt_d;

  vga_if vif_s ();
  vga_if vif_d ();

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1'b1)
  ) dut_s (.clk(clk), .rst(rst), .vout(vif_s), .frame_tick(ft_s), .line_tick(lt_s));

  vga_timing #(
    .H_ACTIVE(D_HA), .H_FP(D_HFP), .H_SYNC(D_HS), .H_BP(D_HBP),
    .V_ACTIVE(D_VA), .V_FP(D_VFP), .V_SYNC(D_VS), .V_BP(D_VBP),
    .SYNC_POL(1'b0)
  ) dut_d (.clk(clk), .rst(rst), .vout(vif_d), .frame_tick(ft_d), .line_tick(lt_d));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock edges since reset release: the raster position is a pure function of it.
  int k;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag, input int kk,
                             input int ha, input int hfp, input int hs, input int hbp,
                             input int va, input int vfp, input int vs, input int vbp,
                             input logic pol,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hsy, input logic vsy, input logic hb, input logic vb,
                             input logic ft, input logic lt);
    int ht, vt, h, v;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    h  = kk % ht;
    v  = (kk / ht) % vt;
    chk({tag, " hcount"}, {21'd0, hc}, h);
    chk({tag, " vcount"}, {21'd0, vc}, v);
    chk({tag, " hblnk"}, {31'd0, hb}, (h >= ha) ? 1 : 0);
    chk({tag, " vblnk"}, {31'd0, vb}, (v >= va) ? 1 : 0);
    chk({tag, " hsync"}, {31'd0, hsy}, (h >= ha + hfp && h < ha + hfp + hs) ? pol : !pol);
    chk({tag, " vsync"}, {31'd0, vsy}, (v >= va + vfp && v < va + vfp + vs) ? pol : !pol);
    chk({tag, " frame_tick"}, {31'd0, ft}, (h == 0 && v == va) ? 1 : 0);
    chk({tag, " line_tick"}, {31'd0, lt}, (h == ha) ? 1 : 0);
  endtask

  task automatic reset_check(input string tag, input logic [10:0] hc, input logic [10:0] vc,
                             input logic hsy, input logic vsy, input logic hb, input logic vb,
                             input logic ft, input logic lt, input logic pol);
    chk({tag, " rst hcount"}, {21'd0, hc}, 0);
    chk({tag, " rst vcount"}, {21'd0, vc}, 0);
    chk({tag, " rst hblnk"}, {31'd0, hb}, 0);
    chk({tag, " rst vblnk"}, {31'd0, vb}, 0);
    chk({tag, " rst hsync"}, {31'd0, hsy}, !pol);
    chk({tag, " rst vsync"}, {31'd0, vsy}, !pol);
    chk({tag, " rst frame_tick"}, {31'd0, ft}, 0);
    chk({tag, " rst line_tick"}, {31'd0, lt}, 0);
  endtask

  // Tallies since the last reset, used to pin the model with literal counts.
  int s_ft_cnt, s_lt_cnt, s_hmax, s_vmax, s_ft_last, s_ft_gap;
  int d_hs_cnt, d_vs_cnt, d_hb_cnt, d_lt_cnt;

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      reset_check("S", vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync,
                  vif_s.hblnk, vif_s.vblnk, ft_s, lt_s, 1'b1);
      reset_check("D", vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.vsync,
                  vif_d.hblnk, vif_d.vblnk, ft_d, lt_d, 1'b0);
      s_ft_cnt = 0; s_lt_cnt = 0; s_hmax = 0; s_vmax = 0; s_ft_last = -1; s_ft_gap = 0;
      d_hs_cnt = 0; d_vs_cnt = 0; d_hb_cnt = 0; d_lt_cnt = 0;
    end else begin
      model_check("S", k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1,
                  vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync,
                  vif_s.hblnk, vif_s.vblnk, ft_s, lt_s);
      model_check("D", k, D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, D_VBP, 1'b0,
                  vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.vsync,
                  vif_d.hblnk, vif_d.vblnk, ft_d, lt_d);
      if (ft_s) begin
        if (s_ft_last >= 0) s_ft_gap = k - s_ft_last;
        s_ft_last = k;
        s_ft_cnt++;
      end
      if (lt_s) s_lt_cnt++;
      if (int'(vif_s.hcount) > s_hmax) s_hmax = int'(vif_s.hcount);
      if (int'(vif_s.vcount) > s_vmax) s_vmax = int'(vif_s.vcount);
      if (vif_d.hsync == 1'b0) d_hs_cnt++;
      if (vif_d.vsync == 1'b0) d_vs_cnt++;
      if (vif_d.hblnk) d_hb_cnt++;
      if (lt_d) d_lt_cnt++;
    end
  end

  task automatic async_reset_and_check();
    rst = 1'b1;
    #1;
    reset_check("S async", vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync,
                vif_s.hblnk, vif_s.vblnk, ft_s, lt_s, 1'b1);
    reset_check("D async", vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.vsync,
                vif_d.hblnk, vif_d.vblnk, ft_d, lt_d, 1'b0);
  endtask

  task automatic release_reset();
    repeat ($urandom_range(1, 3)) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Two full lines of the large raster, 4+ frames of the small one.
    repeat (2112) @(negedge clk);
    #1;
    chk("S frame_tick count", s_ft_cnt, 5);
    chk("S frame_tick gap", s_ft_gap, 448);
    chk("S line_tick count", s_lt_cnt, 75);
    chk("S hcount max", s_hmax, 27);
    chk("S vcount max", s_vmax, 15);
    chk("D hsync low cycles", d_hs_cnt, 256);
    chk("D vsync low cycles", d_vs_cnt, 0);
    chk("D hblnk cycles", d_hb_cnt, 512);
    chk("D line_tick count", d_lt_cnt, 2);
    chk("D vcount after 2 lines", {21'd0, vif_d.vcount}, 2);

    // Randomly timed asynchronous resets, away from clock edges.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 900)) @(posedge clk);
      #($urandom_range(1, 4));
      async_reset_and_check();
      release_reset();
    end

    // Reset mid-line at hcount=500 on the full raster.
    repeat (1556) @(posedge clk);
    #2;
    chk("D pre-reset hcount", {21'd0, vif_d.hcount}, 500);
    chk("D pre-reset vcount", {21'd0, vif_d.vcount}, 1);
    async_reset_and_check();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("S first edge hcount", {21'd0, vif_s.hcount}, 1);
    chk("D first edge hcount", {21'd0, vif_d.hcount}, 1);
    chk("D first edge vcount", {21'd0, vif_d.vcount}, 0);

    // Run the small raster through a couple more frame wraps.
    repeat (1500) @(negedge clk);
    #1;
    chk("S frame_tick count late", s_ft_cnt, 3);
    chk("S frame_tick gap late", s_ft_gap, 448);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
